demux_rr_sched: RTL



---
 rtl/demux_rr_sched.sv | 119 +++++++++++
 1 files changed

// File: rtl/demux_rr_sched.sv
// demux_rr_sched: scheduler for a 1-to-4 demultiplexer.
// Steers a valid/ready input stream into four one-entry output holding
// registers. Steering is round-robin over free channels (mode 0) or chosen
// by in_dest (mode 1). The block also drives the demux select lines and
// counts accepted words.
module demux_rr_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [1:0]         in_dest,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [1:0]         sel,
    output logic [CNT_W-1:0]   xfer_cnt
);

    logic [WIDTH-1:0] chanData_q [4];
    logic [WIDTH-1:0] chanData_d [4];
    logic [3:0]       chanValid_q;
    logic [3:0]       chanValid_d;
    logic [1:0]       ptr_q;
    logic [1:0]       ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [3:0]       free;
    logic             anyFree;
    logic [1:0]       rrTarget;
    logic [1:0]       target;
    logic             xfer;
    logic [3:0]       load;

    // A channel is free when empty or when its consumer drains it this cycle.
    assign free    = ~chanValid_q | out_ready;
    assign anyFree = |free;

    // Round-robin pick: first free channel scanning upward from ptr.
    always_comb begin
        rrTarget = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (free[ptr_q + 2'(k)]) begin
                rrTarget = ptr_q + 2'(k);
            end
        end
    end

    // Target, handshake and select resolution for the current mode.
    always_comb begin
        if (mode) begin
            target   = in_dest;
            in_ready = !rst && free[in_dest];
        end else begin
            target   = rrTarget;
            in_ready = !rst && anyFree;
        end
        sel  = target;
        xfer = in_valid && in_ready;
        load = xfer ? (4'b0001 << target) : 4'b0000;
    end

    // Next-state for channel registers, pointer and counter.
    always_comb begin
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        chanValid_d = chanValid_q;
        for (int i = 0; i < 4; i++) begin
            chanData_d[i] = chanData_q[i];
            if (load[i]) begin
                chanData_d[i]  = in_data;
                chanValid_d[i] = 1'b1;
            end else if (chanValid_q[i] && out_ready[i]) begin
                chanValid_d[i] = 1'b0;
            end
        end
        if (xfer) begin
            cnt_d = cnt_q + 1'b1;
            if (!mode) begin
                ptr_d = target + 2'd1;
            end
        end
    end

    // State registers with synchronous reset that discards held data.
    always_ff @(posedge clk) begin
        if (rst) begin
            chanValid_q <= 4'b0000;
            ptr_q       <= 2'd0;
            cnt_q       <= '0;
            for (int i = 0; i < 4; i++) begin
                chanData_q[i] <= '0;
            end
        end else begin
            chanValid_q <= chanValid_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            for (int i = 0; i < 4; i++) begin
                chanData_q[i] <= chanData_d[i];
            end
        end
    end

    // Flatten channel registers onto the output bus.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            out_data[i*WIDTH +: WIDTH] = chanData_q[i];
        end
    end

    assign out_valid = chanValid_q;
    assign xfer_cnt  = cnt_q;

endmodule
